// File: rtl/rv_mem_arbiter.sv
// rv_mem_arbiter: shares one unified memory port between the IF fetch stage
// and the MEM load/store stage. Grants are combinational from the registered
// state. Reads are sequenced with a fixed-latency counter. Read data is steered
// back to whichever stage owns the read in flight. A starvation counter lets a
// fetch win over continuous data traffic.

module rv_mem_arbiter #(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rstn,

  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [31:0]       if_rdata_o,

  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [63:0]       d_wdata_i,
  input  logic [7:0]        d_strobe_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [63:0]       d_rdata_o,

  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [63:0]       mem_wdata_o,
  output logic [7:0]        mem_strobe_o,
  input  logic [63:0]       mem_rdata_i,

  output logic              busy_o
);

  localparam int unsigned LAT_W = 3;
  localparam int unsigned STV_W = 4;

  localparam logic S_IDLE = 1'b0;
  localparam logic S_WAIT = 1'b1;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  logic             state_q,  state_d;
  logic [LAT_W-1:0] lat_q,    lat_d;
  logic [STV_W-1:0] starve_q, starve_d;
  logic             owner_q,  owner_d;
  logic             half_q,   half_d;

  logic             if_gnt_c;
  logic             d_gnt_c;
  logic             rsp_c;
  logic             unused_c;

  // Byte-offset bits of the fetch address are never used: fetch reads the
  // whole 8-byte word and only bit 2 picks the half.
  assign unused_c = ^if_addr_i[1:0];

  // Grant selection: only in IDLE, data wins unless fetch has been starved
  always_comb begin
    if_gnt_c = 1'b0;
    d_gnt_c  = 1'b0;
    if (rstn && (state_q == S_IDLE)) begin
      if (if_req_i && d_req_i) begin
        if (starve_q == STV_W'(STARVE_MAX)) begin
          if_gnt_c = 1'b1;
        end else begin
          d_gnt_c = 1'b1;
        end
      end else if (if_req_i) begin
        if_gnt_c = 1'b1;
      end else if (d_req_i) begin
        d_gnt_c = 1'b1;
      end
    end
  end

  // Response cycle: the last WAIT cycle, when the counter is down to one
  assign rsp_c = rstn && (state_q == S_WAIT) && (lat_q <= LAT_W'(1));

  // Next-state logic for the FSM, latency counter, owner and half-select
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    owner_d = owner_q;
    half_d  = half_q;
    if (state_q == S_IDLE) begin
      if (if_gnt_c) begin
        owner_d = OWN_IF;
        half_d  = if_addr_i[2];
        lat_d   = LAT_W'(MEM_LAT);
        state_d = S_WAIT;
      end else if (d_gnt_c && !d_we_i) begin
        owner_d = OWN_D;
        lat_d   = LAT_W'(MEM_LAT);
        state_d = S_WAIT;
      end
    end else begin
      lat_d = lat_q - LAT_W'(1);
      if (lat_q <= LAT_W'(1)) begin
        lat_d   = '0;
        state_d = S_IDLE;
      end
    end
  end

  // Starvation counter: counts denied fetch cycles, saturating, cleared on grant
  always_comb begin
    starve_d = starve_q;
    if (if_gnt_c) begin
      starve_d = '0;
    end else if (if_req_i && (starve_q != STV_W'(STARVE_MAX))) begin
      starve_d = starve_q + STV_W'(1);
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      lat_q    <= '0;
      starve_q <= '0;
      owner_q  <= OWN_IF;
      half_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      starve_q <= starve_d;
      owner_q  <= owner_d;
      half_q   <= half_d;
    end
  end

  // Memory port mux: driven from the granted requester, all zero otherwise
  always_comb begin
    mem_en_o     = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    mem_strobe_o = '0;
    if (if_gnt_c) begin
      mem_en_o   = 1'b1;
      mem_addr_o = {if_addr_i[ADDR_W-1:3], 3'b000};
    end else if (d_gnt_c) begin
      mem_en_o   = 1'b1;
      mem_addr_o = d_addr_i;
      if (d_we_i) begin
        mem_we_o     = 1'b1;
        mem_wdata_o  = d_wdata_i;
        mem_strobe_o = d_strobe_i;
      end
    end
  end

  assign if_gnt_o    = if_gnt_c;
  assign d_gnt_o     = d_gnt_c;

  assign if_rvalid_o = rsp_c && (owner_q == OWN_IF);
  assign d_rvalid_o  = rsp_c && (owner_q == OWN_D);

  // Read data steering; zero outside the owner's response cycle
  assign if_rdata_o  = !if_rvalid_o ? 32'd0 :
                       (half_q ? mem_rdata_i[63:32] : mem_rdata_i[31:0]);
  assign d_rdata_o   = d_rvalid_o ? mem_rdata_i : 64'd0;

  assign busy_o      = rstn && (state_q == S_WAIT);

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Testbench for rv_mem_arbiter: directed vector table and corner sequences,
// plus randomized traffic against a transaction-level scheduling model.

module tb_rv_mem_arbiter;

  localparam int unsigned AW = 64;
  localparam int unsigned SMAX = 4;
  localparam logic [63:0] RD0 = 64'hAAAABBBB_CCCCDDDD;
  localparam logic [63:0] RD1 = 64'h11112222_33334444;
  localparam logic [63:0] WD  = 64'h11223344_55667788;

  typedef struct packed {
    logic        if_gnt;
    logic        d_gnt;
    logic        if_rv;
    logic        d_rv;
    logic        en;
    logic        we;
    logic        busy;
    logic [7:0]  strb;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [31:0] if_rdata;
    logic [63:0] d_rdata;
  } obs_t;

  typedef struct {
    logic        if_req;
    logic [63:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic [7:0]  d_strb;
    logic [63:0] rdata;
    obs_t        exp;
  } vec_t;

  logic clk;
  logic rstn;
  logic if_req, d_req, d_we;
  logic [63:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [7:0] d_strobe;

  logic if_gnt_1, if_rvalid_1, d_gnt_1, d_rvalid_1, mem_en_1, mem_we_1, busy_1;
  logic [31:0] if_rdata_1;
  logic [63:0] d_rdata_1, mem_addr_1, mem_wdata_1;
  logic [7:0] mem_strobe_1;

  logic if_gnt_3, if_rvalid_3, d_gnt_3, d_rvalid_3, mem_en_3, mem_we_3, busy_3;
  logic [31:0] if_rdata_3;
  logic [63:0] d_rdata_3, mem_addr_3, mem_wdata_3;
  logic [7:0] mem_strobe_3;

  int n_checks = 0;
  int n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rv_mem_arbiter #(.ADDR_W(AW), .MEM_LAT(1), .STARVE_MAX(SMAX)) u1 (
    .clk(clk), .rstn(rstn),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt_1),
    .if_rvalid_o(if_rvalid_1), .if_rdata_o(if_rdata_1),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_strobe_i(d_strobe), .d_gnt_o(d_gnt_1), .d_rvalid_o(d_rvalid_1),
    .d_rdata_o(d_rdata_1),
    .mem_en_o(mem_en_1), .mem_we_o(mem_we_1), .mem_addr_o(mem_addr_1),
    .mem_wdata_o(mem_wdata_1), .mem_strobe_o(mem_strobe_1),
    .mem_rdata_i(mem_rdata), .busy_o(busy_1)
  );

  rv_mem_arbiter #(.ADDR_W(AW), .MEM_LAT(3), .STARVE_MAX(SMAX)) u3 (
    .clk(clk), .rstn(rstn),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt_3),
    .if_rvalid_o(if_rvalid_3), .if_rdata_o(if_rdata_3),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_strobe_i(d_strobe), .d_gnt_o(d_gnt_3), .d_rvalid_o(d_rvalid_3),
    .d_rdata_o(d_rdata_3),
    .mem_en_o(mem_en_3), .mem_we_o(mem_we_3), .mem_addr_o(mem_addr_3),
    .mem_wdata_o(mem_wdata_3), .mem_strobe_o(mem_strobe_3),
    .mem_rdata_i(mem_rdata), .busy_o(busy_3)
  );

  function automatic obs_t mk_obs(input logic ig, input logic dg, input logic irv,
                                  input logic drv, input logic en, input logic we,
                                  input logic bz, input logic [7:0] st,
                                  input logic [63:0] ad, input logic [63:0] wd,
                                  input logic [31:0] ird, input logic [63:0] drd);
    obs_t o;
    o.if_gnt = ig; o.d_gnt = dg; o.if_rv = irv; o.d_rv = drv;
    o.en = en; o.we = we; o.busy = bz; o.strb = st;
    o.addr = ad; o.wdata = wd; o.if_rdata = ird; o.d_rdata = drd;
    return o;
  endfunction

  // k = 0 selects the MEM_LAT=1 instance, otherwise the MEM_LAT=3 instance
  function automatic obs_t get_obs(input int k);
    if (k == 0)
      return mk_obs(if_gnt_1, d_gnt_1, if_rvalid_1, d_rvalid_1, mem_en_1, mem_we_1,
                    busy_1, mem_strobe_1, mem_addr_1, mem_wdata_1, if_rdata_1, d_rdata_1);
    return mk_obs(if_gnt_3, d_gnt_3, if_rvalid_3, d_rvalid_3, mem_en_3, mem_we_3,
                  busy_3, mem_strobe_3, mem_addr_3, mem_wdata_3, if_rdata_3, d_rdata_3);
  endfunction

  function automatic vec_t mk_vec(input logic ir, input logic [63:0] ia, input logic dr,
                                  input logic dw, input logic [63:0] da,
                                  input logic [63:0] dwd, input logic [7:0] ds,
                                  input logic [63:0] rd, input obs_t e);
    vec_t v;
    v.if_req = ir; v.if_addr = ia; v.d_req = dr; v.d_we = dw; v.d_addr = da;
    v.d_wdata = dwd; v.d_strb = ds; v.rdata = rd; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_val(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [63:0] ia, input logic dr,
                       input logic dw, input logic [63:0] da, input logic [63:0] dwd,
                       input logic [7:0] ds, input logic [63:0] rd);
    if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_addr = da;
    d_wdata = dwd; d_strobe = ds; mem_rdata = rd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rstn = 1'b0;
    drive(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0, 8'd0, 64'd0);
    next_cycle();
    next_cycle();
    rstn = 1'b1;
  endtask

  vec_t tbl[12];
  obs_t zero_o;

  // Scheduling model state, one slot per instance
  int   free_at[2];
  int   resp_at[2];
  int   starve[2];
  logic resp_d[2];
  logic half[2];

  initial begin
    logic ir, dr, dw;
    logic [63:0] ia, da, dwd, rd;
    logic [7:0] ds;
    logic ig, dg, idle, irv, drv;
    logic [63:0] ad;
    obs_t e;
    int lat;

    zero_o = '0;

    tbl[0]  = mk_vec(1, 64'h4, 0, 0, 0, 0, 0, RD0,
                     mk_obs(1, 0, 0, 0, 1, 0, 0, 0, 64'h0, 0, 0, 0));
    tbl[1]  = mk_vec(0, 0, 0, 0, 0, 0, 0, RD0,
                     mk_obs(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 32'hAAAABBBB, 0));
    tbl[2]  = mk_vec(1, 64'h0, 0, 0, 0, 0, 0, RD0,
                     mk_obs(1, 0, 0, 0, 1, 0, 0, 0, 64'h0, 0, 0, 0));
    tbl[3]  = mk_vec(0, 0, 0, 0, 0, 0, 0, RD0,
                     mk_obs(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 32'hCCCCDDDD, 0));
    tbl[4]  = mk_vec(1, 64'h100, 1, 0, 64'h208, 0, 0, RD0,
                     mk_obs(0, 1, 0, 0, 1, 0, 0, 0, 64'h208, 0, 0, 0));
    tbl[5]  = mk_vec(1, 64'h100, 0, 0, 0, 0, 0, RD0,
                     mk_obs(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, RD0));
    tbl[6]  = mk_vec(1, 64'h104, 0, 0, 0, 0, 0, RD1,
                     mk_obs(1, 0, 0, 0, 1, 0, 0, 0, 64'h100, 0, 0, 0));
    tbl[7]  = mk_vec(0, 0, 0, 0, 0, 0, 0, RD1,
                     mk_obs(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 32'h11112222, 0));
    tbl[8]  = mk_vec(0, 0, 1, 1, 64'h40, WD, 8'h0F, RD1,
                     mk_obs(0, 1, 0, 0, 1, 1, 0, 8'h0F, 64'h40, WD, 0, 0));
    tbl[9]  = mk_vec(0, 0, 1, 1, 64'h48, ~WD, 8'hF0, RD1,
                     mk_obs(0, 1, 0, 0, 1, 1, 0, 8'hF0, 64'h48, ~WD, 0, 0));
    tbl[10] = mk_vec(0, 0, 0, 0, 0, 0, 0, RD1,
                     mk_obs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl[11] = mk_vec(1, 64'h200, 1, 1, 64'h50, WD, 8'hFF, RD1,
                     mk_obs(0, 1, 0, 0, 1, 1, 0, 8'hFF, 64'h50, WD, 0, 0));

    // Reset state: requests active, every output (grants included) held at 0
    rstn = 1'b0;
    drive(1'b1, 64'h10, 1'b1, 1'b0, 64'h20, WD, 8'hFF, RD0);
    #2;
    check("reset_outputs_lat1", get_obs(0), zero_o);
    check("reset_outputs_lat3", get_obs(1), zero_o);
    reset_dut();

    // Vector table on the MEM_LAT=1 instance
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].if_req, tbl[i].if_addr, tbl[i].d_req, tbl[i].d_we, tbl[i].d_addr,
            tbl[i].d_wdata, tbl[i].d_strb, tbl[i].rdata);
      #4;
      check($sformatf("vec%0d", i), get_obs(0), tbl[i].exp);
      if (i == 6) check_val("starve_before_if_gnt", longint'(u1.starve_q), 2);
      next_cycle();
    end

    // Starvation: stores every cycle with fetch held high
    reset_dut();
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, 64'h8, 1'b1, 1'b1, 64'h80 + 64'(8 * c), WD, 8'hFF, RD0);
      #4;
      if (c == 4)
        e = mk_obs(1, 0, 0, 0, 1, 0, 0, 0, 64'h8, 0, 0, 0);
      else if (c == 5)
        e = mk_obs(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 32'hCCCCDDDD, 0);
      else
        e = mk_obs(0, 1, 0, 0, 1, 1, 0, 8'hFF, 64'h80 + 64'(8 * c), WD, 0, 0);
      check($sformatf("starve_c%0d", c), get_obs(0), e);
      if (c == 5) check_val("starve_cleared", longint'(u1.starve_q), 0);
      next_cycle();
    end

    // MEM_LAT=3 back-to-back loads
    reset_dut();
    for (int c = 0; c < 9; c++) begin
      rd = RD1 + 64'(c);
      drive(1'b0, 0, 1'b1, 1'b0, 64'h300 + 64'(8 * c), 0, 0, rd);
      #4;
      ig = ((c % 4) == 0);
      irv = ((c % 4) == 3);
      e = mk_obs(0, ig, 0, irv, ig, 0, (c % 4) != 0, 0,
                 ig ? 64'h300 + 64'(8 * c) : 64'd0, 0, 0, irv ? rd : 64'd0);
      check($sformatf("lat3_c%0d", c), get_obs(1), e);
      next_cycle();
    end

    // Reset asserted during an MEM_LAT=3 load
    reset_dut();
    drive(1'b0, 0, 1'b1, 1'b0, 64'h500, 0, 0, RD0);
    #4;
    check("rstwait_grant", get_obs(1), mk_obs(0, 1, 0, 0, 1, 0, 0, 0, 64'h500, 0, 0, 0));
    next_cycle();
    rstn = 1'b0;
    drive(1'b1, 64'h10, 1'b1, 1'b0, 64'h500, 0, 0, RD0);
    #1;
    check("rstwait_immediate", get_obs(1), zero_o);
    #3;
    next_cycle();
    check("rstwait_held", get_obs(1), zero_o);
    rstn = 1'b1;
    drive(1'b1, 64'h10, 1'b0, 1'b0, 0, 0, 0, RD0);
    #4;
    check("rstwait_first_if", get_obs(1), mk_obs(1, 0, 0, 0, 1, 0, 0, 0, 64'h10, 0, 0, 0));
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      drive(1'b0, 0, 1'b0, 1'b0, 0, 0, 0, RD0);
      #4;
      check_val($sformatf("rstwait_no_drvalid%0d", c), longint'(d_rvalid_3), 0);
    end
    next_cycle();

    // Randomized traffic against the scheduling model, both instances
    reset_dut();
    for (int k = 0; k < 2; k++) begin
      free_at[k] = 0; resp_at[k] = -1; starve[k] = 0; resp_d[k] = 1'b0; half[k] = 1'b0;
    end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      ir  = 1'($urandom_range(0, 1));
      dr  = 1'($urandom_range(0, 1));
      dw  = 1'($urandom_range(0, 1));
      ia  = {$urandom, $urandom} & ~64'h3;
      da  = {$urandom, $urandom} & ~64'h7;
      dwd = {$urandom, $urandom};
      ds  = 8'($urandom);
      rd  = {$urandom, $urandom};
      drive(ir, ia, dr, dw, da, dwd, ds, rd);
      #4;
      for (int k = 0; k < 2; k++) begin
        lat  = (k == 0) ? 1 : 3;
        idle = (cyc >= free_at[k]);
        ig = 1'b0;
        dg = 1'b0;
        if (idle) begin
          if (ir && dr) begin
            if (starve[k] == SMAX) ig = 1'b1;
            else dg = 1'b1;
          end else if (ir) ig = 1'b1;
          else if (dr) dg = 1'b1;
        end
        irv = (resp_at[k] == cyc) && !resp_d[k];
        drv = (resp_at[k] == cyc) && resp_d[k];
        ad  = ig ? {ia[63:3], 3'b000} : (dg ? da : 64'd0);
        e = mk_obs(ig, dg, irv, drv, ig | dg, dg & dw, !idle,
                   (dg && dw) ? ds : 8'd0, ad, (dg && dw) ? dwd : 64'd0,
                   irv ? (half[k] ? rd[63:32] : rd[31:0]) : 32'd0,
                   drv ? rd : 64'd0);
        check($sformatf("rand_k%0d_c%0d", k, cyc), get_obs(k), e);
        if (ig) starve[k] = 0;
        else if (ir && starve[k] < SMAX) starve[k]++;
        if (ig || (dg && !dw)) begin
          free_at[k] = cyc + lat + 1;
          resp_at[k] = cyc + lat;
          resp_d[k]  = dg;
          half[k]    = ia[2];
        end
      end
      next_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
